// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone B4 classic slave port between NUM_MASTERS masters.
// The grant is held for the owner's whole cyc window; a watchdog aborts transfers the slave never acks.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS*AW-1:0] m_adr_i,
  input  logic [NUM_MASTERS*32-1:0] m_dat_i,
  input  logic [NUM_MASTERS*4-1:0]  m_sel_i,
  output logic [31:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [AW-1:0]             s_adr_o,
  output logic [31:0]               s_dat_o,
  output logic [3:0]                s_sel_o,
  input  logic [31:0]               s_dat_i,
  input  logic                      s_ack_i,
  output logic [NUM_MASTERS-1:0]    grant_o,
  output logic [1:0]                state_o
);

  // Handshake: a beat completes in any cycle where cyc & stb & ack are all high; the master
  // may change adr/dat/we/sel only after such a cycle and ends its bus cycle by dropping cyc.

  localparam int PW    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int WW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WD_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t                 state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [PW-1:0]          ptr_q;
  logic [PW-1:0]          owner_q;
  logic [WW-1:0]          wdog_q;

  logic [NUM_MASTERS-1:0] grant_d;
  logic [PW-1:0]          owner_d;
  logic                   found;
  logic [PW-1:0]          idx;
  logic                   own_cyc;
  logic                   own_stb;
  logic                   timeout_hit;

  // Next owner: first requester strictly after the last owner, wrapping around.
  always_comb begin
    grant_d = '0;
    owner_d = ptr_q;
    found   = 1'b0;
    idx     = '0;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      idx = PW'((int'(ptr_q) + off) % NUM_MASTERS);
      if (!found && m_cyc_i[idx]) begin
        found        = 1'b1;
        grant_d[idx] = 1'b1;
        owner_d      = idx;
      end
    end
  end

  // AND-OR mux of the owner's signals; all zero while no grant is held.
  always_comb begin
    own_cyc = |(m_cyc_i & grant_q);
    own_stb = |(m_stb_i & grant_q);
    s_we_o  = |(m_we_i & grant_q);
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        s_adr_o = s_adr_o | m_adr_i[i*AW +: AW];
        s_dat_o = s_dat_o | m_dat_i[i*32 +: 32];
        s_sel_o = s_sel_o | m_sel_i[i*4 +: 4];
      end
    end
  end

  assign s_cyc_o     = (state_q == OWNED) && own_cyc;
  assign s_stb_o     = s_cyc_o && own_stb;
  assign timeout_hit = WD_EN && s_stb_o && !s_ack_i && (wdog_q == WW'(TIMEOUT - 1));
  assign m_ack_o     = grant_q & {NUM_MASTERS{s_ack_i && (state_q == OWNED)}};
  assign m_err_o     = grant_q & {NUM_MASTERS{timeout_hit}};
  assign m_dat_o     = s_dat_i;
  assign grant_o     = grant_q;
  assign state_o     = state_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= PW'(NUM_MASTERS - 1);
      owner_q <= '0;
      wdog_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wdog_q <= '0;
          if (found) begin
            grant_q <= grant_d;
            owner_q <= owner_d;
            state_q <= OWNED;
          end
        end
        OWNED: begin
          if (!own_cyc) begin
            grant_q <= '0;
            ptr_q   <= owner_q;
            wdog_q  <= '0;
            state_q <= IDLE;
          end else if (timeout_hit) begin
            wdog_q  <= '0;
            state_q <= ABORT;
          end else if (WD_EN && s_stb_o && !s_ack_i) begin
            wdog_q <= wdog_q + 1'b1;
          end else begin
            wdog_q <= '0;
          end
        end
        ABORT: begin
          // Bus stays released until the aborted owner gives up its cycle.
          if (!own_cyc) begin
            grant_q <= '0;
            ptr_q   <= owner_q;
            state_q <= IDLE;
          end
        end
        default: begin
          grant_q <= '0;
          wdog_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (2 masters, TIMEOUT=8) with hand-computed expectations.
module tb_wb_rr_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  m_cyc = '0, m_stb = '0, m_we = '0;
  logic [N*AW-1:0] m_adr = '0;
  logic [N*32-1:0] m_dat = '0;
  logic [N*4-1:0]  m_sel = '0;
  logic [31:0]   s_dat_in = '0;
  logic          s_ack = 1'b0;

  logic [31:0]   m_dat_o;
  logic [N-1:0]  m_ack_o, m_err_o, grant_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [31:0]   s_dat_o;
  logic [3:0]    s_sel_o;
  logic [1:0]    state_o;

  int tests = 0;
  int fails = 0;

  wb_rr_arbiter #(.NUM_MASTERS(N), .AW(AW), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_in), .s_ack_i(s_ack),
    .grant_o(grant_o), .state_o(state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver: advance n rising edges and land 2 ns after the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset held, then released with no requests
    step(2);
    chk("rst_grant", 32'(grant_o), 32'(2'b00));
    chk("rst_scyc", 32'(s_cyc_o), 32'(1'b0));
    chk("rst_state", 32'(state_o), 32'(2'd0));
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("idle_bus", 32'({s_cyc_o, s_stb_o, s_we_o, grant_o, m_ack_o, m_err_o}), 32'(0));
      chk("idle_adr", s_adr_o, 32'h0);
    end

    // M0 single write, slave acks one cycle after the grant
    m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01;
    m_adr[31:0] = 32'h04; m_dat[31:0] = 32'hDEADBEEF; m_sel[3:0] = 4'hF;
    #1;
    chk("wr_not_yet", 32'(s_cyc_o), 32'(1'b0));
    step(1);
    chk("wr_grant", 32'(grant_o), 32'(2'b01));
    chk("wr_scyc", 32'({s_cyc_o, s_stb_o, s_we_o}), 32'(3'b111));
    chk("wr_adr", s_adr_o, 32'h04);
    chk("wr_dat", s_dat_o, 32'hDEADBEEF);
    chk("wr_sel", 32'(s_sel_o), 32'hF);
    s_ack = 1'b1; s_dat_in = 32'hCAFE0001;
    #1;
    chk("wr_ack", 32'(m_ack_o), 32'(2'b01));
    chk("rd_bcast", m_dat_o, 32'hCAFE0001);
    step(1);
    m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0;
    #1;
    chk("wr_ack_off", 32'(m_ack_o), 32'(2'b00));
    chk("wr_scyc_off", 32'(s_cyc_o), 32'(1'b0));
    step(1);
    chk("wr_release", 32'(grant_o), 32'(2'b00));
    chk("wr_state", 32'(state_o), 32'(2'd0));

    // both masters request together; last owner M0 so M1 goes first, then alternate
    m_adr[63:32] = 32'h100; m_cyc = 2'b11; m_stb = 2'b11;
    for (int r = 0; r < 4; r++) begin
      logic [1:0] exp_g;
      exp_g = (r % 2 == 0) ? 2'b10 : 2'b01;
      step(1);
      chk("rr_grant", 32'(grant_o), 32'(exp_g));
      s_ack = 1'b1;
      #1;
      chk("rr_ack", 32'(m_ack_o), 32'(exp_g));
      step(1);
      m_cyc = m_cyc & ~exp_g; m_stb = m_stb & ~exp_g; s_ack = 1'b0;
      step(1);
      chk("rr_gap", 32'(grant_o), 32'(2'b00));
      if (r < 3) begin
        m_cyc = 2'b11; m_stb = 2'b11;
      end else begin
        m_cyc = 2'b00; m_stb = 2'b00;
      end
    end

    // M1 holds a 3-beat cycle while M0 waits; M0's inputs must not leak onto the slave
    m_adr[31:0] = 32'h200; m_cyc = 2'b11; m_stb = 2'b11;
    step(1);
    chk("burst_grant", 32'(grant_o), 32'(2'b10));
    chk("burst_adr", s_adr_o, 32'h100);
    s_ack = 1'b1;
    for (int b = 0; b < 3; b++) begin
      #1;
      chk("burst_ack", 32'(m_ack_o), 32'(2'b10));
      step(1);
    end
    m_cyc = 2'b01; m_stb = 2'b01; s_ack = 1'b0;
    #1;
    chk("burst_hold", 32'(grant_o), 32'(2'b10));
    chk("burst_noack", 32'(m_ack_o), 32'(2'b00));
    step(1);
    chk("burst_gap", 32'({s_cyc_o, grant_o}), 32'(3'b000));
    step(1);
    chk("burst_next", 32'(grant_o), 32'(2'b01));
    chk("burst_next_adr", s_adr_o, 32'h200);
    m_cyc = '0; m_stb = '0;
    step(1);
    chk("burst_done", 32'(grant_o), 32'(2'b00));

    // watchdog: slave never acks, error on the 8th waiting cycle
    m_adr[31:0] = 32'h10; m_cyc = 2'b01; m_stb = 2'b01;
    step(1);
    chk("wd_grant", 32'(grant_o), 32'(2'b01));
    for (int k = 1; k <= 8; k++) begin
      chk("wd_err", 32'(m_err_o), (k == 8) ? 32'(2'b01) : 32'(2'b00));
      if (k < 8) step(1);
    end
    step(1);
    chk("wd_abort_state", 32'(state_o), 32'(2'd2));
    chk("wd_abort_bus", 32'({s_cyc_o, s_stb_o, m_err_o}), 32'(4'b0000));
    chk("wd_abort_grant", 32'(grant_o), 32'(2'b01));
    step(2);
    chk("wd_abort_hold", 32'(s_cyc_o), 32'(1'b0));
    m_cyc = '0; m_stb = '0;
    step(1);
    chk("wd_recover", 32'({state_o, grant_o}), 32'(4'b0000));

    // ack in the threshold cycle wins over the watchdog
    m_cyc = 2'b01; m_stb = 2'b01;
    step(1);
    step(7);
    s_ack = 1'b1;
    #1;
    chk("wd_ackwin_err", 32'(m_err_o), 32'(2'b00));
    chk("wd_ackwin_ack", 32'(m_ack_o), 32'(2'b01));
    step(1);
    s_ack = 1'b0;
    #1;
    chk("wd_ackwin_state", 32'(state_o), 32'(2'd1));
    chk("wd_ackwin_err2", 32'(m_err_o), 32'(2'b00));
    m_cyc = '0; m_stb = '0;
    step(1);
    chk("wd_ackwin_idle", 32'(state_o), 32'(2'd0));

    // asynchronous reset mid-transfer, M0 first afterwards
    m_cyc = 2'b10; m_stb = 2'b10;
    step(1);
    chk("mr_grant", 32'({s_cyc_o, grant_o}), 32'(3'b110));
    rst_n = 1'b0;
    #1;
    chk("mr_drop", 32'({s_cyc_o, s_stb_o, grant_o}), 32'(4'b0000));
    step(2);
    m_cyc = 2'b11; m_stb = 2'b11; rst_n = 1'b1;
    step(1);
    chk("mr_first", 32'(grant_o), 32'(2'b01));
    m_cyc = '0; m_stb = '0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
